// File: rtl/rv32i_pkg.sv
// Shared constants and types for the RV32I decode/execute slice.
package rv32i_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [6:0] FUNCT7_ALT = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_NONE = 4'd0,
    ALU_ADD  = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_AND  = 4'd3,
    ALU_OR   = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SLL  = 4'd6,
    ALU_SRL  = 4'd7,
    ALU_SRA  = 4'd8,
    ALU_SLT  = 4'd9,
    ALU_SLTU = 4'd10,
    ALU_EQ   = 4'd11,
    ALU_NE   = 4'd12,
    ALU_GE   = 4'd13,
    ALU_GEU  = 4'd14
  } alu_op_e;

  // Decoded control word for one instruction.
  typedef struct packed {
    logic        branch;
    logic        mem_read;
    logic        mem_write;
    alu_op_e     alu_op;
    logic        alu_src;
    logic        reg_write;
    logic [31:0] imm;
  } dec_t;

  // Shared OP / OP-IMM funct3 mapping; alt selects SUB / SRA.
  function automatic alu_op_e arith_op(input logic [2:0] funct3, input logic alt);
    alu_op_e op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv32i_regfile.sv
// 32-entry register file: async clear, x0 hardwired to zero, write-through reads, debug taps.
module rv32i_regfile
  import rv32i_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [4:0]      rd_addr,
  input  logic [XLEN-1:0] w_val,
  input  logic [4:0]      ra1,
  input  logic [4:0]      ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic [XLEN-1:0] debug_ra,
  output logic [XLEN-1:0] debug_sp,
  output logic [XLEN-1:0] debug_t0,
  output logic [XLEN-1:0] debug_t1,
  output logic [XLEN-1:0] debug_t2,
  output logic [XLEN-1:0] debug_a0,
  output logic [XLEN-1:0] debug_a1
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];

  // Next-state: apply writeback, keep x0 pinned at zero.
  always_comb begin
    regs_d = regs_q;
    if (rd_addr != '0) regs_d[rd_addr] = w_val;
    regs_d[0] = '0;
  end

  // Storage with asynchronous clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) regs_q <= '{default: '0};
    else       regs_q <= regs_d;
  end

  // Read ports: x0 reads zero, same-cycle writeback is forwarded.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (ra1 != '0) rd1 = (ra1 == rd_addr) ? w_val : regs_q[ra1];
    if (ra2 != '0) rd2 = (ra2 == rd_addr) ? w_val : regs_q[ra2];
  end

  assign debug_ra = regs_q[1];
  assign debug_sp = regs_q[2];
  assign debug_t0 = regs_q[5];
  assign debug_t1 = regs_q[6];
  assign debug_t2 = regs_q[7];
  assign debug_a0 = regs_q[10];
  assign debug_a1 = regs_q[11];

endmodule

// File: rtl/rv32i_id_ex_unit.sv
// Decode + register read + ALU slice of the RV32I pipeline.
module rv32i_id_ex_unit
  import rv32i_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [31:0]     instr_raw,
  input  logic [4:0]      rd_addr,
  input  logic [XLEN-1:0] w_val,
  output logic            branch,
  output logic            mem_read,
  output logic            mem_write,
  output logic [3:0]      alu_op,
  output logic            alu_src,
  output logic            reg_write,
  output logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] rs1_val,
  output logic [XLEN-1:0] rs2_val,
  output logic [XLEN-1:0] alu_result,
  output logic [XLEN-1:0] debug_ra,
  output logic [XLEN-1:0] debug_sp,
  output logic [XLEN-1:0] debug_t0,
  output logic [XLEN-1:0] debug_t1,
  output logic [XLEN-1:0] debug_t2,
  output logic [XLEN-1:0] debug_a0,
  output logic [XLEN-1:0] debug_a1
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [31:0]     imm_i;
  logic [31:0]     imm_s;
  logic [31:0]     imm_b;
  dec_t            dec;
  alu_op_e         br_op;
  logic [XLEN-1:0] src2;
  logic [4:0]      shamt;
  logic [XLEN-1:0] alu_res;

  assign opcode = instr_raw[6:0];
  assign funct3 = instr_raw[14:12];
  assign funct7 = instr_raw[31:25];
  assign imm_i  = {{20{instr_raw[31]}}, instr_raw[31:20]};
  assign imm_s  = {{20{instr_raw[31]}}, instr_raw[31:25], instr_raw[11:7]};
  assign imm_b  = {{19{instr_raw[31]}}, instr_raw[31], instr_raw[7],
                   instr_raw[30:25], instr_raw[11:8], 1'b0};

  rv32i_regfile #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_regfile (
    .clock    (clock),
    .reset    (reset),
    .rd_addr  (rd_addr),
    .w_val    (w_val),
    .ra1      (instr_raw[19:15]),
    .ra2      (instr_raw[24:20]),
    .rd1      (rs1_val),
    .rd2      (rs2_val),
    .debug_ra (debug_ra),
    .debug_sp (debug_sp),
    .debug_t0 (debug_t0),
    .debug_t1 (debug_t1),
    .debug_t2 (debug_t2),
    .debug_a0 (debug_a0),
    .debug_a1 (debug_a1)
  );

  // Branch funct3 to comparison op; 010/011 have no branch meaning.
  always_comb begin
    case (funct3)
      3'b000:  br_op = ALU_EQ;
      3'b001:  br_op = ALU_NE;
      3'b100:  br_op = ALU_SLT;
      3'b101:  br_op = ALU_GE;
      3'b110:  br_op = ALU_SLTU;
      3'b111:  br_op = ALU_GEU;
      default: br_op = ALU_NONE;
    endcase
  end

  // Instruction decode; anything unsupported leaves the all-zero NOP word.
  always_comb begin
    dec = '0;
    case (opcode)
      OPC_OP: begin
        dec.alu_op    = arith_op(funct3, funct7 == FUNCT7_ALT);
        dec.reg_write = TRUE;
      end
      OPC_OP_IMM: begin
        dec.alu_op    = arith_op(funct3, (funct3 == 3'b101) && instr_raw[30]);
        dec.alu_src   = TRUE;
        dec.reg_write = TRUE;
        dec.imm       = imm_i;
      end
      OPC_LOAD: begin
        dec.alu_op    = ALU_ADD;
        dec.alu_src   = TRUE;
        dec.mem_read  = TRUE;
        dec.reg_write = TRUE;
        dec.imm       = imm_i;
      end
      OPC_STORE: begin
        dec.alu_op    = ALU_ADD;
        dec.alu_src   = TRUE;
        dec.mem_write = TRUE;
        dec.imm       = imm_s;
      end
      OPC_BRANCH: begin
        if (br_op != ALU_NONE) begin
          dec.branch = TRUE;
          dec.alu_op = br_op;
          dec.imm    = imm_b;
        end
      end
      default: dec = '0;
    endcase
  end

  // ALU: rs1 op (imm or rs2); comparisons yield 0/1.
  always_comb begin
    src2    = dec.alu_src ? dec.imm : rs2_val;
    shamt   = src2[4:0];
    alu_res = '0;
    case (dec.alu_op)
      ALU_ADD:  alu_res = rs1_val + src2;
      ALU_SUB:  alu_res = rs1_val - src2;
      ALU_AND:  alu_res = rs1_val & src2;
      ALU_OR:   alu_res = rs1_val | src2;
      ALU_XOR:  alu_res = rs1_val ^ src2;
      ALU_SLL:  alu_res = rs1_val << shamt;
      ALU_SRL:  alu_res = rs1_val >> shamt;
      ALU_SRA:  alu_res = $signed(rs1_val) >>> shamt;
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(rs1_val) < $signed(src2)};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, rs1_val < src2};
      ALU_EQ:   alu_res = {{(XLEN-1){1'b0}}, rs1_val == src2};
      ALU_NE:   alu_res = {{(XLEN-1){1'b0}}, rs1_val != src2};
      ALU_GE:   alu_res = {{(XLEN-1){1'b0}}, $signed(rs1_val) >= $signed(src2)};
      ALU_GEU:  alu_res = {{(XLEN-1){1'b0}}, rs1_val >= src2};
      default:  alu_res = '0;
    endcase
  end

  assign branch     = dec.branch;
  assign mem_read   = dec.mem_read;
  assign mem_write  = dec.mem_write;
  assign alu_op     = dec.alu_op;
  assign alu_src    = dec.alu_src;
  assign reg_write  = dec.reg_write;
  assign imm        = dec.imm;
  assign alu_result = alu_res;

endmodule

// File: tb/tb_rv32i_id_ex_unit.sv
// Self-checking bench: directed scenarios plus randomized instructions vs a mnemonic-level model.
module tb_rv32i_id_ex_unit;
  import rv32i_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] instr_raw;
  logic [4:0]  rd_addr;
  logic [31:0] w_val;
  logic        branch, mem_read, mem_write, alu_src, reg_write;
  logic [3:0]  alu_op;
  logic [31:0] imm, rs1_val, rs2_val, alu_result;
  logic [31:0] debug_ra, debug_sp, debug_t0, debug_t1, debug_t2, debug_a0, debug_a1;

  int n_run  = 0;
  int n_fail = 0;
  logic [31:0] xm [32];

  typedef struct packed {
    logic        br, mr, mw;
    logic [3:0]  op;
    logic        src, rw, imm_ok;
    logic [31:0] imm, res;
  } exp_t;

  rv32i_id_ex_unit #(.XLEN(32), .NREGS(32)) dut (
    .clock(clock), .reset(reset), .instr_raw(instr_raw), .rd_addr(rd_addr), .w_val(w_val),
    .branch(branch), .mem_read(mem_read), .mem_write(mem_write), .alu_op(alu_op),
    .alu_src(alu_src), .reg_write(reg_write), .imm(imm), .rs1_val(rs1_val), .rs2_val(rs2_val),
    .alu_result(alu_result), .debug_ra(debug_ra), .debug_sp(debug_sp), .debug_t0(debug_t0),
    .debug_t1(debug_t1), .debug_t2(debug_t2), .debug_a0(debug_a0), .debug_a1(debug_a1)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sx12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

  function automatic logic [31:0] shr_arith(input logic [31:0] v, input logic [4:0] s);
    logic [31:0] ones = 32'hFFFF_FFFF;
    return (v >> s) | (v[31] ? ~(ones >> s) : 32'h0);
  endfunction

  // Architectural result of an operation named by its spec code.
  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
    int sa = a;
    int sb = b;
    case (op)
      1:  return a + b;
      2:  return a - b;
      3:  return a & b;
      4:  return a | b;
      5:  return a ^ b;
      6:  return a << b[4:0];
      7:  return a >> b[4:0];
      8:  return shr_arith(a, b[4:0]);
      9:  return (sa < sb) ? 32'd1 : 32'd0;
      10: return (a < b) ? 32'd1 : 32'd0;
      11: return (a == b) ? 32'd1 : 32'd0;
      12: return (a != b) ? 32'd1 : 32'd0;
      13: return (sa >= sb) ? 32'd1 : 32'd0;
      14: return (a >= b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] rd_model(input logic [4:0] a, input logic [4:0] wa, input logic [31:0] wv);
    if (a == 5'd0) return 32'd0;
    if (a == wa)   return wv;
    return xm[a];
  endfunction

  task automatic drive(input logic [31:0] ins, input logic [4:0] wa, input logic [31:0] wv);
    @(negedge clock);
    instr_raw = ins;
    rd_addr   = wa;
    w_val     = wv;
    #1;
  endtask

  task automatic commit();
    @(posedge clock);
    if (rd_addr != 5'd0) xm[rd_addr] = w_val;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] v);
    drive(INST_NOP, a, v);
    commit();
  endtask

  task automatic chk_dbg(input string tag);
    chk({tag, ".ra"}, debug_ra, xm[1]);
    chk({tag, ".sp"}, debug_sp, xm[2]);
    chk({tag, ".t0"}, debug_t0, xm[5]);
    chk({tag, ".t1"}, debug_t1, xm[6]);
    chk({tag, ".t2"}, debug_t2, xm[7]);
    chk({tag, ".a0"}, debug_a0, xm[10]);
    chk({tag, ".a1"}, debug_a1, xm[11]);
  endtask

  task automatic chk_ctl(input string tag, input logic br, input logic mr, input logic mw,
                         input logic [3:0] op, input logic src, input logic rw);
    chk({tag, ".branch"}, branch, br);
    chk({tag, ".mem_read"}, mem_read, mr);
    chk({tag, ".mem_write"}, mem_write, mw);
    chk({tag, ".alu_op"}, alu_op, op);
    chk({tag, ".alu_src"}, alu_src, src);
    chk({tag, ".reg_write"}, reg_write, rw);
  endtask

  task automatic chk_exp(input string tag, input logic [31:0] ins, input logic [4:0] wa,
                         input logic [31:0] wv, input exp_t e);
    chk_ctl(tag, e.br, e.mr, e.mw, e.op, e.src, e.rw);
    if (e.imm_ok) chk({tag, ".imm"}, imm, e.imm);
    chk({tag, ".result"}, alu_result, e.res);
    chk({tag, ".rs1"}, rs1_val, rd_model(ins[19:15], wa, wv));
    chk({tag, ".rs2"}, rs2_val, rd_model(ins[24:20], wa, wv));
    chk_dbg(tag);
  endtask

  // Build a random instruction from a mnemonic choice and its expected effect.
  task automatic gen(input logic [4:0] wa, input logic [31:0] wv, output logic [31:0] ins, output exp_t e);
    int r_op[10]  = '{1, 2, 6, 9, 10, 5, 7, 8, 4, 3};
    int r_f3[10]  = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
    int r_alt[10] = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 0};
    int i_op[9]   = '{1, 9, 10, 5, 4, 3, 6, 7, 8};
    int i_f3[9]   = '{0, 2, 3, 4, 6, 7, 1, 5, 5};
    int b_op[6]   = '{11, 12, 9, 13, 10, 14};
    int b_f3[6]   = '{0, 1, 4, 5, 6, 7};
    int u_opc[10] = '{'h37, 'h17, 'h6F, 'h67, 'h0F, 'h73, 'h7F, 'h00, 'h2F, 'h53};
    logic [4:0]  r1, r2, rd;
    logic [2:0]  f3;
    logic [11:0] i12;
    logic [12:0] i13;
    logic [31:0] a1, a2, rnd;
    int k, sel;
    r1  = 5'($urandom_range(0, 31));
    r2  = ($urandom_range(0, 3) == 0) ? r1 : 5'($urandom_range(0, 31));
    rd  = 5'($urandom_range(0, 31));
    f3  = 3'($urandom_range(0, 7));
    rnd = $urandom;
    i12 = rnd[11:0];
    i13 = {rnd[23:12], 1'b0};
    a1  = rd_model(r1, wa, wv);
    a2  = rd_model(r2, wa, wv);
    e   = '0;
    k   = $urandom_range(0, 5);
    case (k)
      0: begin
        sel   = $urandom_range(0, 9);
        ins   = {(r_alt[sel] != 0) ? 7'b0100000 : 7'b0000000, r2, r1, 3'(r_f3[sel]), rd, 7'b0110011};
        e.op  = 4'(r_op[sel]);
        e.rw  = 1'b1;
        e.res = ref_alu(r_op[sel], a1, a2);
      end
      1: begin
        sel = $urandom_range(0, 8);
        if (sel >= 6) i12 = {(sel == 8) ? 7'b0100000 : 7'b0000000, rnd[28:24]};
        ins      = {i12, r1, 3'(i_f3[sel]), rd, 7'b0010011};
        e.op     = 4'(i_op[sel]);
        e.src    = 1'b1;
        e.rw     = 1'b1;
        e.imm_ok = 1'b1;
        e.imm    = sx12(i12);
        e.res    = ref_alu(i_op[sel], a1, e.imm);
      end
      2: begin
        ins      = {i12, r1, f3, rd, 7'b0000011};
        e.op     = 4'd1;
        e.src    = 1'b1;
        e.mr     = 1'b1;
        e.rw     = 1'b1;
        e.imm_ok = 1'b1;
        e.imm    = sx12(i12);
        e.res    = a1 + e.imm;
      end
      3: begin
        ins      = {i12[11:5], r2, r1, f3, i12[4:0], 7'b0100011};
        e.op     = 4'd1;
        e.src    = 1'b1;
        e.mw     = 1'b1;
        e.imm_ok = 1'b1;
        e.imm    = sx12(i12);
        e.res    = a1 + e.imm;
      end
      4: begin
        sel      = $urandom_range(0, 5);
        ins      = {i13[12], i13[10:5], r2, r1, 3'(b_f3[sel]), i13[4:1], i13[11], 7'b1100011};
        e.op     = 4'(b_op[sel]);
        e.br     = 1'b1;
        e.imm_ok = 1'b1;
        e.imm    = {{19{i13[12]}}, i13};
        e.res    = ref_alu(b_op[sel], a1, a2);
      end
      default: begin
        sel = $urandom_range(0, 11);
        ins = $urandom;
        if (sel < 10) begin
          ins[6:0] = 7'(u_opc[sel]);
        end else begin
          ins[6:0]   = 7'b1100011;
          ins[14:12] = (sel == 10) ? 3'b010 : 3'b011;
        end
        e.imm_ok = 1'b1;
      end
    endcase
  endtask

  initial begin
    logic [31:0] ins, wv;
    logic [4:0]  wa;
    exp_t        e;

    for (int i = 0; i < 32; i++) xm[i] = 32'd0;
    reset = 1'b1; instr_raw = INST_NOP; rd_addr = 5'd0; w_val = 32'd0;
    #1;
    chk_dbg("reset");
    chk("reset.nop_rw", reg_write, 1'b1);
    @(negedge clock);
    reset = 1'b0;

    // Mid-run reset clears stored registers immediately.
    wr(5'd5, 32'd7);
    drive(32'h0002_8013, 5'd0, 32'd0);
    chk("pre_rst.rs1", rs1_val, 32'd7);
    chk("pre_rst.t0", debug_t0, 32'd7);
    reset = 1'b1;
    #1;
    for (int i = 0; i < 32; i++) xm[i] = 32'd0;
    chk_dbg("mid_rst");
    chk("mid_rst.rs1", rs1_val, 32'd0);
    #1 reset = 1'b0;

    // Write-through bypass and x0 behaviour.
    drive(32'h0000_8013, 5'd1, 32'hDEAD_BEEF);
    chk("bypass.rs1", rs1_val, 32'hDEAD_BEEF);
    chk("bypass.ra_old", debug_ra, 32'd0);
    commit();
    drive(32'h0000_8013, 5'd0, 32'd0);
    chk("stored.ra", debug_ra, 32'hDEAD_BEEF);
    chk("stored.rs1", rs1_val, 32'hDEAD_BEEF);
    drive(INST_NOP, 5'd0, 32'h1234_5678);
    chk("x0.rs1", rs1_val, 32'd0);
    commit();
    drive(INST_NOP, 5'd0, 32'd0);
    chk("x0.after", rs1_val, 32'd0);

    // ADDI x10,x0,-5 then SRAI x11,x10,1.
    drive(32'hFFB0_0513, 5'd10, 32'hFFFF_FFFB);
    chk_ctl("addi", 1'b0, 1'b0, 1'b0, 4'd1, 1'b1, 1'b1);
    chk("addi.imm", imm, 32'hFFFF_FFFB);
    chk("addi.result", alu_result, 32'hFFFF_FFFB);
    commit();
    drive(32'h4015_5593, 5'd0, 32'd0);
    chk("srai.op", alu_op, 4'd8);
    chk("srai.result", alu_result, 32'hFFFF_FFFD);

    // SW x6,8(x2).
    wr(5'd2, 32'h10);
    wr(5'd6, 32'h0000_CAFE);
    drive(32'h0061_2423, 5'd0, 32'd0);
    chk_ctl("sw", 1'b0, 1'b0, 1'b1, 4'd1, 1'b1, 1'b0);
    chk("sw.imm", imm, 32'd8);
    chk("sw.result", alu_result, 32'h18);
    chk("sw.rs2", rs2_val, 32'h0000_CAFE);

    // Branches on x5/x6.
    wr(5'd5, 32'd3);
    wr(5'd6, 32'd3);
    drive(32'hFE62_8CE3, 5'd0, 32'd0);
    chk_ctl("beq", 1'b1, 1'b0, 1'b0, 4'd11, 1'b0, 1'b0);
    chk("beq.imm", imm, 32'hFFFF_FFF8);
    chk("beq.taken", alu_result, 32'd1);
    wr(5'd6, 32'd4);
    drive(32'hFE62_8CE3, 5'd0, 32'd0);
    chk("beq.not_taken", alu_result, 32'd0);
    wr(5'd5, 32'hFFFF_FFFF);
    wr(5'd6, 32'd1);
    drive(32'hFE62_CCE3, 5'd0, 32'd0);
    chk("blt.result", alu_result, 32'd1);
    drive(32'hFE62_ECE3, 5'd0, 32'd0);
    chk("bltu.result", alu_result, 32'd0);

    // LW and NOP-decoded encodings.
    drive(32'h0040_2383, 5'd0, 32'd0);
    chk_ctl("lw", 1'b0, 1'b1, 1'b0, 4'd1, 1'b1, 1'b1);
    chk("lw.result", alu_result, 32'd4);
    drive(32'h1234_52B7, 5'd0, 32'd0);
    chk_ctl("lui", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    chk("lui.imm", imm, 32'd0);
    chk("lui.result", alu_result, 32'd0);
    drive(32'hFE62_ACE3, 5'd0, 32'd0);
    chk_ctl("br010", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    chk("br010.result", alu_result, 32'd0);

    // Fill every register, then random instructions with concurrent writeback.
    for (int r = 1; r < 32; r++) wr(5'(r), $urandom);
    for (int it = 0; it < 400; it++) begin
      wa = 5'($urandom_range(0, 31));
      wv = $urandom;
      gen(wa, wv, ins, e);
      drive(ins, wa, wv);
      chk_exp("rnd", ins, wa, wv, e);
      commit();
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/rv32i_id_ex_unit.md
Name: rv32i_id_ex_unit

Overview:
- Decode-plus-execute slice of the 5-stage RV32I core.
- Combines three parts:
  - instruction decoder (control bits and immediate);
  - 32x32 register file with a writeback port;
  - combinational ALU computing rs1 op (imm or rs2).
- Feeds the ID/EX and EX/MEM pipeline registers. A taken branch is flagged by branch=1 together with alu_result != 0.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- NREGS, 32, number of architectural registers.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears the register file.
- instr_raw  in  32  instruction in ID.
- rd_addr  in  5  writeback destination (0 = no write).
- w_val  in  32  writeback data.
- branch  out  1  conditional branch.
- mem_read  out  1  load.
- mem_write  out  1  store.
- alu_op  out  4  ALU operation code.
- alu_src  out  1  1 = ALU operand 2 is imm, 0 = rs2.
- reg_write  out  1  instruction writes rd.
- imm  out  32  sign-extended immediate.
- rs1_val  out  32  value of x[instr_raw[19:15]].
- rs2_val  out  32  value of x[instr_raw[24:20]].
- alu_result  out  32  ALU output for the current operands.
- debug_ra, debug_sp, debug_t0, debug_t1, debug_t2, debug_a0, debug_a1  out  32 each  live values of x1, x2, x5, x6, x7, x10, x11.

Behaviour:
- Timing
  - All outputs except the register-file state are combinational from instr_raw and the stored registers.
  - Only sequential element: the register file.
- Reset
  - Asynchronous assert clears x1..x31 to 0, so every debug output reads 0.
  - Decode outputs remain a pure function of instr_raw during reset.
- Register file
  - Write on the rising edge when rd_addr != 0.
  - x0 always reads 0; writes to x0 are discarded.
  - Reads are combinational with write-through: if a read address equals rd_addr != 0 in the same cycle, the read returns w_val.
- ALU codes
  - NONE=0, ADD=1, SUB=2, AND=3, OR=4, XOR=5, SLL=6, SRL=7, SRA=8, SLT=9, SLTU=10, EQ=11, NE=12, GE=13, GEU=14; code 15 is reserved.
- ALU semantics
  - Shifts use src2[4:0].
  - SLT, SLTU, EQ, NE, GE and GEU return 32'd1 or 32'd0.
  - Signed comparisons are two's complement.
  - ADD and SUB wrap modulo 2^32.
  - NONE and reserved codes return 0.
- Decode table (any control not listed is 0)
  - OP (0110011): alu_src=0, reg_write=1.
    - funct3 000: ADD, or SUB when funct7=0100000.
    - 001 SLL, 010 SLT, 011 SLTU, 100 XOR.
    - 101: SRL, or SRA when funct7=0100000.
    - 110 OR, 111 AND.
  - OP-IMM (0010011): same funct3 mapping, alu_src=1, reg_write=1, I-immediate.
    - funct3 000 is always ADD.
    - 101 is SRAI when instr[30]=1, else SRLI.
  - LOAD (0000011): ADD, alu_src=1, mem_read=1, reg_write=1, I-immediate.
  - STORE (0100011): ADD, alu_src=1, mem_write=1, S-immediate.
  - BRANCH (1100011): branch=1, alu_src=0, B-immediate (bit0=0).
    - funct3 000 EQ, 001 NE, 100 SLT, 101 GE, 110 SLTU, 111 GEU.
    - funct3 010 and 011 decode as NOP.
- Unsupported instructions
  - LUI, AUIPC, JAL, JALR, FENCE, SYSTEM and unknown opcodes decode as NOP: all controls 0, alu_op=NONE, imm=0.
- alu_result is computed as alu_op applied to (rs1_val, alu_src ? imm : rs2_val).
- The NOP encoding 0x00000013 yields reg_write=1 with rd=0, so it is harmless.

Decomposition:
- Package rv32i_pkg:
  - opcode constants;
  - ALU_* codes;
  - TRUE/FALSE;
  - INST_NOP = 32'h00000013.
- One natural sub-module: rv32i_regfile (storage, async reset, write-through, debug taps).
- Decoder and ALU are combinational blocks inside the top.

Test Plan:
- Reset mid-run after writing x5=7 -> all debug outputs read 0 immediately, and rs1_val of x5 reads 0.
- Write rd_addr=1, w_val=0xDEADBEEF, with instr_raw reading rs1=x1 in the same cycle -> rs1_val=0xDEADBEEF (bypass); the following cycle debug_ra=0xDEADBEEF. Write to rd=0 -> x0 still reads 0.
- ADDI x10,x0,-5 (0xFFB00513) -> imm=0xFFFFFFFB, alu_src=1, reg_write=1, alu_op=ADD, alu_result=0xFFFFFFFB. SRAI x11,x10,1 with x10=0xFFFFFFFB -> alu_result=0xFFFFFFFD.
- SW x6,8(x2) with sp=0x10 (0x00612423) -> mem_write=1, reg_write=0, imm=8, alu_result=0x18, rs2_val=x6.
- BEQ x5,x6,-8 (0xFE628CE3) with x5=x6=3 -> branch=1, imm=0xFFFFFFF8, alu_result=1. With x6=4 -> alu_result=0. BLT with x5=0xFFFFFFFF, x6=1 -> result 1; BLTU with the same values -> result 0.
- LW x7,4(x0) (0x00402383) -> mem_read=1, reg_write=1, alu_result=4. LUI (0x123452B7) and funct3=010 branch -> all controls 0, alu_op=0, alu_result=0.
